load_align_unit: RTL and testbench

Multi-cycle, parametrised load unit between the core's memory stage and the data-memory port. It accepts a load request: funct3 plus a byte address. It issues one or two aligned bus reads and extracts the addressed byte, halfword, word or doubleword. The result is sign- or zero-extended to XLEN. Misaligned loads that span two bus words are split into two beats, or faulted, as selected by parameter.

---
 rtl/load_align_unit_if.sv | 46 ++++
 rtl/load_align_unit.sv | 169 ++++++++++++++++
 tb/tb_load_align_unit.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_align_unit_if.sv
// load_align_unit_if
// Bundles the three handshakes around the load unit: the core-side load
// request, the data-memory read port and the result channel.
//   req_valid / req_ready / req_funct3 / req_addr     : load request
//   mem_req_valid / mem_req_ready / mem_addr           : bus read request
//   mem_rvalid / mem_rdata                             : bus read data
//   rsp_valid / rsp_ready / rsp_data / rsp_fault       : load result
// The slave modport is the load unit itself; the master modport is its
// environment (core plus memory), which drives requests and bus replies.
interface load_align_unit_if #(
   parameter int XLEN = 32
);

   logic            req_valid;
   logic            req_ready;
   logic [2:0]      req_funct3;
   logic [31:0]     req_addr;

   logic            mem_req_valid;
   logic            mem_req_ready;
   logic [31:0]     mem_addr;
   logic            mem_rvalid;
   logic [XLEN-1:0] mem_rdata;

   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_data;
   logic            rsp_fault;

   modport master (
      output req_valid, req_funct3, req_addr,
      output mem_req_ready, mem_rvalid, mem_rdata,
      output rsp_ready,
      input  req_ready, mem_req_valid, mem_addr,
      input  rsp_valid, rsp_data, rsp_fault
   );

   modport slave (
      input  req_valid, req_funct3, req_addr,
      input  mem_req_ready, mem_rvalid, mem_rdata,
      input  rsp_ready,
      output req_ready, mem_req_valid, mem_addr,
      output rsp_valid, rsp_data, rsp_fault
   );

endinterface

// File: rtl/load_align_unit.sv
// load_align_unit
// Multi-cycle load unit between the memory stage and the data-memory port.
// A request (funct3 + byte address) is turned into one or two aligned bus
// reads; the addressed byte/halfword/word/doubleword is extracted from the
// returned little-endian data and sign- or zero-extended to XLEN.
// Ports:
//   clk  : single clock
//   rst  : synchronous, active-high reset
//   bus  : load_align_unit_if.slave (request, bus read and result channels)
// Parameters:
//   XLEN          : 32 or 64; LD and LWU are only legal at 64
//   MISALIGNED_EN : 1 splits a load that crosses a bus word into two reads,
//                   0 reports it as a fault instead
module load_align_unit #(
   parameter int XLEN          = 32,
   parameter bit MISALIGNED_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   load_align_unit_if.slave   bus
);

   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);

   typedef enum logic [2:0] {
      IDLE,
      REQ0,
      WAIT0,
      REQ1,
      WAIT1,
      RESP
   } state_t;

   state_t          state;
   state_t          state_next;

   logic [2:0]      funct3_q;
   logic [31:0]     base_q;
   logic [OFFW-1:0] off_q;
   logic            split_q;
   logic [XLEN-1:0] lo_q;
   logic [XLEN-1:0] rsp_data_q;
   logic            rsp_fault_q;

   logic [4:0]      size_d;
   logic [OFFW-1:0] off_d;
   logic            split_d;
   logic            fault_d;

   logic [XLEN-1:0] lo_src;
   logic [XLEN-1:0] hi_src;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] extended;

   // Decode the incoming request while it waits in IDLE: access size from
   // funct3[1:0], byte offset inside the bus word, whether it runs past the
   // end of that word, and whether the request must be refused outright.
   always_comb begin
      case (bus.req_funct3[1:0])
         2'b00:   size_d = 5'd1;
         2'b01:   size_d = 5'd2;
         2'b10:   size_d = 5'd4;
         default: size_d = 5'd8;
      endcase
      off_d   = bus.req_addr[OFFW-1:0];
      split_d = (5'(off_d) + size_d) > 5'(NB);
      fault_d = (bus.req_funct3 == 3'b111)
             || ((XLEN == 32) && ((bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110)))
             || (split_d && !MISALIGNED_EN);
   end

   // State register. Reset drops any access in flight; a late read beat
   // afterwards lands in IDLE where nothing looks at it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. Faulting requests skip the bus entirely and go
   // straight to the response; only split accesses visit REQ1/WAIT1.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (bus.req_valid)     state_next = fault_d ? RESP : REQ0;
         REQ0:    if (bus.mem_req_ready) state_next = WAIT0;
         WAIT0:   if (bus.mem_rvalid)    state_next = split_q ? REQ1 : RESP;
         REQ1:    if (bus.mem_req_ready) state_next = WAIT1;
         WAIT1:   if (bus.mem_rvalid)    state_next = RESP;
         RESP:    if (bus.rsp_ready)     state_next = IDLE;
         default:                        state_next = IDLE;
      endcase
   end

   // Outputs decoded from state. The bus address is a pure function of the
   // registered base and the state, so it cannot move while a request is
   // stalled; the second beat wraps naturally in 32-bit arithmetic.
   always_comb begin
      bus.req_ready     = (state == IDLE) && !rst;
      bus.mem_req_valid = (state == REQ0) || (state == REQ1);
      bus.mem_addr      = '0;
      if (state == REQ0) begin
         bus.mem_addr = base_q;
      end else if (state == REQ1) begin
         bus.mem_addr = base_q + 32'(NB);
      end
      bus.rsp_valid = (state == RESP);
      bus.rsp_data  = rsp_data_q;
      bus.rsp_fault = rsp_fault_q;
   end

   // Extraction. The final beat's data comes straight from the bus so the
   // result can be registered on the same edge it arrives; for a split
   // access the first beat is the low half held in lo_q. The pair is
   // shifted down by the byte offset and the access size picks the
   // extension; the size casts sign-extend the $signed slices.
   always_comb begin
      lo_src  = (state == WAIT1) ? lo_q : bus.mem_rdata;
      hi_src  = (state == WAIT1) ? bus.mem_rdata : '0;
      shifted = XLEN'({hi_src, lo_src} >> {off_q, 3'b000});
      case (funct3_q)
         3'b000:  extended = XLEN'($signed(shifted[7:0]));
         3'b001:  extended = XLEN'($signed(shifted[15:0]));
         3'b010:  extended = XLEN'($signed(shifted[31:0]));
         3'b100:  extended = XLEN'(shifted[7:0]);
         3'b101:  extended = XLEN'(shifted[15:0]);
         3'b110:  extended = XLEN'(shifted[31:0]);
         default: extended = shifted;
      endcase
   end

   // Request capture, first-beat capture and result register. A fault is
   // decided at acceptance and its (zero) data is written right away; a
   // good load overwrites data and clears the fault flag when its last
   // beat arrives. Nothing here changes while sitting in RESP, which keeps
   // the result stable under consumer backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         funct3_q    <= 3'b000;
         base_q      <= '0;
         off_q       <= '0;
         split_q     <= 1'b0;
         lo_q        <= '0;
         rsp_data_q  <= '0;
         rsp_fault_q <= 1'b0;
      end else begin
         if ((state == IDLE) && bus.req_valid) begin
            funct3_q    <= bus.req_funct3;
            base_q      <= {bus.req_addr[31:OFFW], {OFFW{1'b0}}};
            off_q       <= off_d;
            split_q     <= split_d;
            rsp_fault_q <= fault_d;
            rsp_data_q  <= '0;
         end
         if ((state == WAIT0) && bus.mem_rvalid) begin
            lo_q <= bus.mem_rdata;
         end
         if (((state == WAIT0) && bus.mem_rvalid && !split_q) ||
             ((state == WAIT1) && bus.mem_rvalid)) begin
            rsp_data_q  <= extended;
            rsp_fault_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit
// Self-checking bench for load_align_unit. Three units share clk/rst and
// the stimulus signals: sel=0 is XLEN=32 with split loads, sel=1 is XLEN=32
// with misaligned loads faulted, sel=2 is XLEN=64. Only the selected unit
// sees request/handshake inputs; its outputs are muxed back for checking.
// Expected results come from a byte-addressed memory model and the load
// rules (size, offset, extension, fault conditions, latency).
module tb_load_align_unit;

   logic        clk;
   logic        rst;
   int          sel;

   logic        req_valid;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic        mem_req_ready;
   logic        mem_rvalid;
   logic [63:0] mem_rdata;
   logic        rsp_ready;

   logic        o_req_ready;
   logic        o_mem_req_valid;
   logic [31:0] o_mem_addr;
   logic        o_rsp_valid;
   logic [63:0] o_rsp_data;
   logic        o_rsp_fault;

   int          n_checks;
   int          n_errors;

   logic [7:0]  mem_model [logic [31:0]];

   load_align_unit_if #(.XLEN(32)) if_a ();
   load_align_unit_if #(.XLEN(32)) if_b ();
   load_align_unit_if #(.XLEN(64)) if_c ();

   load_align_unit #(.XLEN(32), .MISALIGNED_EN(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
   load_align_unit #(.XLEN(32), .MISALIGNED_EN(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
   load_align_unit #(.XLEN(64), .MISALIGNED_EN(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

   // Route the shared stimulus to every unit, gating the handshake inputs
   // so only the selected unit ever sees activity.
   assign if_a.req_valid     = req_valid && (sel == 0);
   assign if_a.req_funct3    = req_funct3;
   assign if_a.req_addr      = req_addr;
   assign if_a.mem_req_ready = mem_req_ready && (sel == 0);
   assign if_a.mem_rvalid    = mem_rvalid && (sel == 0);
   assign if_a.mem_rdata     = mem_rdata[31:0];
   assign if_a.rsp_ready     = rsp_ready && (sel == 0);

   assign if_b.req_valid     = req_valid && (sel == 1);
   assign if_b.req_funct3    = req_funct3;
   assign if_b.req_addr      = req_addr;
   assign if_b.mem_req_ready = mem_req_ready && (sel == 1);
   assign if_b.mem_rvalid    = mem_rvalid && (sel == 1);
   assign if_b.mem_rdata     = mem_rdata[31:0];
   assign if_b.rsp_ready     = rsp_ready && (sel == 1);

   assign if_c.req_valid     = req_valid && (sel == 2);
   assign if_c.req_funct3    = req_funct3;
   assign if_c.req_addr      = req_addr;
   assign if_c.mem_req_ready = mem_req_ready && (sel == 2);
   assign if_c.mem_rvalid    = mem_rvalid && (sel == 2);
   assign if_c.mem_rdata     = mem_rdata;
   assign if_c.rsp_ready     = rsp_ready && (sel == 2);

   // Bring the selected unit's outputs back onto common observation wires.
   always_comb begin
      o_req_ready     = 1'b0;
      o_mem_req_valid = 1'b0;
      o_mem_addr      = '0;
      o_rsp_valid     = 1'b0;
      o_rsp_data      = '0;
      o_rsp_fault     = 1'b0;
      case (sel)
         0: begin
            o_req_ready = if_a.req_ready;  o_mem_req_valid = if_a.mem_req_valid;
            o_mem_addr  = if_a.mem_addr;   o_rsp_valid     = if_a.rsp_valid;
            o_rsp_data  = 64'(if_a.rsp_data); o_rsp_fault  = if_a.rsp_fault;
         end
         1: begin
            o_req_ready = if_b.req_ready;  o_mem_req_valid = if_b.mem_req_valid;
            o_mem_addr  = if_b.mem_addr;   o_rsp_valid     = if_b.rsp_valid;
            o_rsp_data  = 64'(if_b.rsp_data); o_rsp_fault  = if_b.rsp_fault;
         end
         default: begin
            o_req_ready = if_c.req_ready;  o_mem_req_valid = if_c.mem_req_valid;
            o_mem_addr  = if_c.mem_addr;   o_rsp_valid     = if_c.rsp_valid;
            o_rsp_data  = if_c.rsp_data;   o_rsp_fault     = if_c.rsp_fault;
         end
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      return mem_model.exists(a) ? mem_model[a] : 8'h00;
   endfunction

   function automatic void write_bytes(input logic [31:0] a, input logic [63:0] d, input int nbytes);
      for (int i = 0; i < nbytes; i++) begin
         mem_model[a + 32'(i)] = d[8*i +: 8];
      end
   endfunction

   // Eight consecutive bytes starting at a bus address; the 32-bit units
   // only see the low four.
   function automatic logic [63:0] bus_word(input logic [31:0] a);
      logic [63:0] w;
      w = '0;
      for (int i = 0; i < 8; i++) begin
         w[8*i +: 8] = mem_byte(a + 32'(i));
      end
      return w;
   endfunction

   // Reference model: read the addressed bytes, extend them, and decide
   // fault, bus addresses and number of reads from the load rules.
   function automatic void model(input int sl, input logic [2:0] f3, input logic [31:0] a,
                                 output bit fault, output logic [63:0] data, output int beats,
                                 output logic [31:0] a0, output logic [31:0] a1);
      int          xlen;
      int          nb;
      int          size;
      int          off;
      bit          split;
      logic [63:0] raw;
      logic [63:0] mask;
      xlen  = (sl == 2) ? 64 : 32;
      nb    = xlen / 8;
      size  = 1 << f3[1:0];
      off   = int'(a % 32'(nb));
      split = (off + size) > nb;
      fault = (f3 == 3'b111) || ((xlen == 32) && ((f3 == 3'b011) || (f3 == 3'b110))) ||
              (split && (sl == 1));
      a0    = a - 32'(off);
      a1    = a0 + 32'(nb);
      beats = fault ? 0 : (split ? 2 : 1);
      data  = '0;
      if (!fault) begin
         raw = '0;
         for (int i = 0; i < size; i++) begin
            raw = raw | (64'(mem_byte(a + 32'(i))) << (8 * i));
         end
         if (size < 8) begin
            mask = (64'd1 << (8 * size)) - 64'd1;
            if (!f3[2] && raw[8*size-1]) begin
               raw = raw | ~mask;
            end
         end
         data = (xlen == 32) ? (raw & 64'hFFFF_FFFF) : raw;
      end
   endfunction

   // One complete load on the selected unit: request, bus replies with the
   // given request stalls and read-data delay, response held back for
   // rsp_stall cycles, then handshake and return to idle.
   task automatic apply_stimulus(input logic [2:0] f3, input logic [31:0] a,
                                 input int req_stall, input int rv_delay, input int rsp_stall);
      bit          exp_fault;
      logic [63:0] exp_data;
      int          exp_beats;
      logic [31:0] a0;
      logic [31:0] a1;
      int          exp_lat;
      int          cycles;
      int          reads;
      int          stall_left;
      int          rv_left;
      bit          waiting_data;
      bit          req_open;
      bit          got;
      logic [31:0] held_addr;

      model(sel, f3, a, exp_fault, exp_data, exp_beats, a0, a1);
      exp_lat = exp_fault ? 1 : 1 + 2 * exp_beats + exp_beats * (req_stall + rv_delay);

      @(negedge clk);
      check_output("req_ready_idle", 64'(o_req_ready), 64'd1);
      req_valid     = 1'b1;
      req_funct3    = f3;
      req_addr      = a;
      mem_req_ready = 1'b0;
      mem_rvalid    = 1'b0;
      rsp_ready     = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;

      cycles       = 1;
      reads        = 0;
      stall_left   = 0;
      rv_left      = 0;
      waiting_data = 1'b0;
      req_open     = 1'b0;
      got          = 1'b0;
      held_addr    = '0;
      while (!got && cycles < 64) begin
         @(negedge clk);
         mem_req_ready = 1'b0;
         mem_rvalid    = 1'b0;
         if (req_open) begin
            check_output("mem_req_held", 64'(o_mem_req_valid), 64'd1);
            check_output("mem_addr_held", 64'(o_mem_addr), 64'(held_addr));
         end
         if (o_rsp_valid) begin
            got = 1'b1;
         end else if (o_mem_req_valid && !waiting_data) begin
            if (!req_open) begin
               held_addr = o_mem_addr;
               if (reads < 2) begin
                  check_output("mem_addr", 64'(o_mem_addr), 64'((reads == 0) ? a0 : a1));
               end
               reads++;
               req_open   = 1'b1;
               stall_left = req_stall;
            end
            if (stall_left > 0) begin
               stall_left--;
            end else begin
               mem_req_ready = 1'b1;
               req_open      = 1'b0;
               waiting_data  = 1'b1;
               rv_left       = rv_delay;
            end
         end else if (waiting_data) begin
            if (rv_left > 0) begin
               rv_left--;
            end else begin
               mem_rvalid   = 1'b1;
               mem_rdata    = bus_word(held_addr);
               waiting_data = 1'b0;
            end
         end
         if (!got) begin
            @(posedge clk);
            cycles++;
         end
      end

      check_output("rsp_arrived", 64'(got), 64'd1);
      check_output("bus_reads", 64'(reads), 64'(exp_beats));
      if (got) begin
         check_output("latency", 64'(cycles), 64'(exp_lat));
         check_output("rsp_fault", 64'(o_rsp_fault), 64'(exp_fault));
         check_output("rsp_data", o_rsp_data, exp_data);
         for (int i = 0; i < rsp_stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_output("rsp_valid_held", 64'(o_rsp_valid), 64'd1);
            check_output("rsp_data_held", o_rsp_data, exp_data);
            check_output("req_ready_busy", 64'(o_req_ready), 64'd0);
         end
         rsp_ready = 1'b1;
         @(posedge clk);
         #1 rsp_ready = 1'b0;
         @(negedge clk);
         check_output("rsp_valid_done", 64'(o_rsp_valid), 64'd0);
         check_output("req_ready_again", 64'(o_req_ready), 64'd1);
      end
   endtask

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      sel           = 0;
      rst           = 1'b1;
      req_valid     = 1'b0;
      req_funct3    = 3'b000;
      req_addr      = '0;
      mem_req_ready = 1'b0;
      mem_rvalid    = 1'b0;
      mem_rdata     = '0;
      rsp_ready     = 1'b0;

      write_bytes(32'h0000_1000, 64'h0000_0000_F2F4_F6F8, 4);
      write_bytes(32'h0000_1004, 64'h0000_0000_1122_3344, 4);
      write_bytes(32'hFFFF_FFFC, 64'h0000_0000_A5B6_C7D8, 4);

      // Reset values on all three units
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check_output("rst_req_ready", 64'(o_req_ready), 64'd0);
         check_output("rst_mem_req_valid", 64'(o_mem_req_valid), 64'd0);
         check_output("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
         check_output("rst_rsp_fault", 64'(o_rsp_fault), 64'd0);
         check_output("rst_rsp_data", o_rsp_data, 64'd0);
         check_output("rst_mem_addr", 64'(o_mem_addr), 64'd0);
      end
      sel = 0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_output("post_rst_req_ready", 64'(o_req_ready), 64'd1);

      // Aligned loads, XLEN=32
      $display("[TB] aligned loads");
      sel = 0;
      apply_stimulus(3'b000, 32'h0000_1001, 0, 0, 0);
      apply_stimulus(3'b100, 32'h0000_1003, 0, 0, 0);
      apply_stimulus(3'b001, 32'h0000_1002, 0, 0, 0);
      apply_stimulus(3'b101, 32'h0000_1000, 0, 0, 0);
      apply_stimulus(3'b010, 32'h0000_1000, 0, 0, 0);

      // Split loads and their faulted counterpart
      $display("[TB] split loads");
      apply_stimulus(3'b010, 32'h0000_1003, 0, 0, 0);
      apply_stimulus(3'b001, 32'h0000_1003, 0, 0, 0);
      sel = 1;
      apply_stimulus(3'b010, 32'h0000_1003, 0, 0, 0);
      apply_stimulus(3'b010, 32'h0000_1000, 0, 0, 0);

      // Illegal funct3 at XLEN=32
      $display("[TB] illegal funct3");
      sel = 0;
      apply_stimulus(3'b011, 32'h0000_1000, 0, 0, 0);
      apply_stimulus(3'b111, 32'h0000_1000, 0, 0, 0);
      apply_stimulus(3'b110, 32'h0000_1000, 0, 0, 0);

      // XLEN=64 doubleword and word loads
      $display("[TB] XLEN=64 loads");
      write_bytes(32'h0000_0000, 64'h8000_0000_0000_0001, 8);
      sel = 2;
      apply_stimulus(3'b011, 32'h0000_0000, 0, 0, 0);
      apply_stimulus(3'b110, 32'h0000_0004, 0, 0, 0);
      apply_stimulus(3'b010, 32'h0000_0004, 0, 0, 0);

      // Backpressure on bus and result, plus address wrap on split
      $display("[TB] backpressure");
      sel = 0;
      apply_stimulus(3'b010, 32'h0000_1000, 3, 1, 2);
      apply_stimulus(3'b010, 32'h0000_1003, 1, 2, 1);
      apply_stimulus(3'b010, 32'hFFFF_FFFE, 0, 0, 0);

      // Reset in the middle of an access
      $display("[TB] reset mid-access");
      sel = 0;
      @(negedge clk);
      req_valid  = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h0000_1000;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check_output("midrst_req_issued", 64'(o_mem_req_valid), 64'd1);
      mem_req_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mem_req_ready = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst        = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = bus_word(32'h0000_1000);
      @(posedge clk);
      @(negedge clk);
      mem_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_output("midrst_no_rsp", 64'(o_rsp_valid), 64'd0);
         check_output("midrst_idle", 64'(o_req_ready), 64'd1);
         check_output("midrst_no_req", 64'(o_mem_req_valid), 64'd0);
         @(negedge clk);
      end
      apply_stimulus(3'b100, 32'h0000_1000, 0, 0, 0);

      // Randomized loads against the reference model
      $display("[TB] random loads");
      for (int i = 0; i < 64; i++) begin
         mem_model[32'h0000_2000 + 32'(i)] = 8'($urandom);
      end
      for (int i = 0; i < 40; i++) begin
         sel = int'($urandom_range(0, 2));
         apply_stimulus(3'($urandom_range(0, 7)),
                        32'h0000_2000 + 32'($urandom_range(0, 55)),
                        int'($urandom_range(0, 2)),
                        int'($urandom_range(0, 2)),
                        int'($urandom_range(0, 2)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
